// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage RV32I pipeline: redirects, load-use bubbles, memory backpressure.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module pipe_hazard_ctrl #(
    parameter int TIMEOUT_CYC = 255,
    parameter int CNT_W       = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jump_en_i,
    input  logic [31:0] jump_addr_i,
    input  logic        ex_is_load_i,
    input  logic [4:0]  ex_rd_addr_i,
    input  logic [4:0]  id_rs1_addr_i,
    input  logic [4:0]  id_rs2_addr_i,
    input  logic        id_rs1_used_i,
    input  logic        id_rs2_used_i,
    input  logic        mem_busy_i,
    output logic        jump_en_o,
    output logic [31:0] jump_addr_o,
    output logic        hold_pc_o,
    output logic        hold_if_id_o,
    output logic        hold_id_ex_o,
    output logic        hold_ex_mem_o,
    output logic        flush_if_id_o,
    output logic        flush_id_ex_o,
    output logic        err_timeout_o
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] perf_lu_cnt_o,
    output logic [31:0] perf_flush_cnt_o,
    output logic [31:0] perf_mem_stall_cnt_o
`endif
);

    typedef enum logic [1:0] {RUN, MEM_WAIT, JUMP_PEND} state_t;

    localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    state_t             state_reg, state_next;
    logic [31:0]        pend_addr_reg, pend_addr_next;
    logic [CNT_W-1:0]   busy_cnt_reg, busy_cnt_next;
    logic               err_reg, err_next;
    logic               lu;

    assign lu = ex_is_load_i && (ex_rd_addr_i != 5'd0) &&
                ((id_rs1_used_i && (id_rs1_addr_i == ex_rd_addr_i)) ||
                 (id_rs2_used_i && (id_rs2_addr_i == ex_rd_addr_i)));

    always_comb begin
        state_next     = state_reg;
        pend_addr_next = pend_addr_reg;
        jump_en_o      = 1'b0;
        jump_addr_o    = (state_reg == JUMP_PEND) ? pend_addr_reg : jump_addr_i;
        hold_pc_o      = 1'b0;
        hold_if_id_o   = 1'b0;
        hold_id_ex_o   = 1'b0;
        hold_ex_mem_o  = 1'b0;
        flush_if_id_o  = 1'b0;
        flush_id_ex_o  = 1'b0;
        err_timeout_o  = err_reg;

        if (mem_busy_i) begin
            hold_pc_o     = 1'b1;
            hold_if_id_o  = 1'b1;
            hold_id_ex_o  = 1'b1;
            hold_ex_mem_o = 1'b1;
        end

        case (state_reg)
            JUMP_PEND: begin
                // The held EX instruction already produced this redirect; new jump_en_i is stale.
                if (!mem_busy_i) begin
                    jump_en_o     = 1'b1;
                    flush_if_id_o = 1'b1;
                    flush_id_ex_o = 1'b1;
                    state_next    = RUN;
                end
            end
            default: begin
                // RUN and MEM_WAIT share one decode: a busy release resumes with no added latency.
                if (mem_busy_i) begin
                    if (jump_en_i) begin
                        pend_addr_next = jump_addr_i;
                        state_next     = JUMP_PEND;
                    end else begin
                        state_next     = MEM_WAIT;
                    end
                end else begin
                    state_next = RUN;
                    if (jump_en_i) begin
                        jump_en_o     = 1'b1;
                        flush_if_id_o = 1'b1;
                        flush_id_ex_o = 1'b1;
                    end else if (lu) begin
                        hold_pc_o     = 1'b1;
                        hold_if_id_o  = 1'b1;
                        flush_id_ex_o = 1'b1;
                    end
                end
            end
        endcase

        if (!rst) begin
            jump_en_o     = 1'b0;
            jump_addr_o   = 32'd0;
            hold_pc_o     = 1'b0;
            hold_if_id_o  = 1'b0;
            hold_id_ex_o  = 1'b0;
            hold_ex_mem_o = 1'b0;
            flush_if_id_o = 1'b0;
            flush_id_ex_o = 1'b0;
            err_timeout_o = 1'b0;
        end
    end

    always_comb begin
        busy_cnt_next = '0;
        if (mem_busy_i) begin
            busy_cnt_next = (busy_cnt_reg == CNT_MAX) ? CNT_MAX : busy_cnt_reg + 1'b1;
        end
        err_next = err_reg || (mem_busy_i && (busy_cnt_next >= TIMEOUT_V));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg     <= RUN;
            pend_addr_reg <= 32'd0;
            busy_cnt_reg  <= '0;
            err_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            pend_addr_reg <= pend_addr_next;
            busy_cnt_reg  <= busy_cnt_next;
            err_reg       <= err_next;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    // A load-use bubble is the only decode that flushes ID/EX without flushing IF/ID.
    logic lu_bubble;
    assign lu_bubble = flush_id_ex_o && !flush_if_id_o;

    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_lu_cnt_o        <= 32'd0;
            perf_flush_cnt_o     <= 32'd0;
            perf_mem_stall_cnt_o <= 32'd0;
        end else begin
            perf_lu_cnt_o        <= perf_lu_cnt_o + {31'd0, lu_bubble};
            perf_flush_cnt_o     <= perf_flush_cnt_o + {31'd0, jump_en_o};
            perf_mem_stall_cnt_o <= perf_mem_stall_cnt_o + {31'd0, mem_busy_i};
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed vector table, hand sequences for timeout/reset, random vs reference model.
module tb_pipe_hazard_ctrl;

    localparam int TO = 4;

    typedef struct packed {
        logic        rst;
        logic        je;
        logic [31:0] ja;
        logic        ld;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        u1;
        logic        u2;
        logic        busy;
    } in_t;

    typedef struct packed {
        logic        je;
        logic [31:0] ja;
        logic        hpc;
        logic        hif;
        logic        hie;
        logic        hem;
        logic        fif;
        logic        fie;
        logic        err;
    } out_t;

    typedef struct {
        string name;
        in_t   in;
        out_t  exp;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        jump_en_i;
    logic [31:0] jump_addr_i;
    logic        ex_is_load_i;
    logic [4:0]  ex_rd_addr_i;
    logic [4:0]  id_rs1_addr_i;
    logic [4:0]  id_rs2_addr_i;
    logic        id_rs1_used_i;
    logic        id_rs2_used_i;
    logic        mem_busy_i;
    logic        jump_en_o;
    logic [31:0] jump_addr_o;
    logic        hold_pc_o;
    logic        hold_if_id_o;
    logic        hold_id_ex_o;
    logic        hold_ex_mem_o;
    logic        flush_if_id_o;
    logic        flush_id_ex_o;
    logic        err_timeout_o;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] perf_lu_cnt_o;
    logic [31:0] perf_flush_cnt_o;
    logic [31:0] perf_mem_stall_cnt_o;
`endif

    int total = 0;
    int bad   = 0;

    pipe_hazard_ctrl #(.TIMEOUT_CYC(TO), .CNT_W(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .jump_en_i     (jump_en_i),
        .jump_addr_i   (jump_addr_i),
        .ex_is_load_i  (ex_is_load_i),
        .ex_rd_addr_i  (ex_rd_addr_i),
        .id_rs1_addr_i (id_rs1_addr_i),
        .id_rs2_addr_i (id_rs2_addr_i),
        .id_rs1_used_i (id_rs1_used_i),
        .id_rs2_used_i (id_rs2_used_i),
        .mem_busy_i    (mem_busy_i),
        .jump_en_o     (jump_en_o),
        .jump_addr_o   (jump_addr_o),
        .hold_pc_o     (hold_pc_o),
        .hold_if_id_o  (hold_if_id_o),
        .hold_id_ex_o  (hold_id_ex_o),
        .hold_ex_mem_o (hold_ex_mem_o),
        .flush_if_id_o (flush_if_id_o),
        .flush_id_ex_o (flush_id_ex_o),
        .err_timeout_o (err_timeout_o)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .perf_lu_cnt_o        (perf_lu_cnt_o),
        .perf_flush_cnt_o     (perf_flush_cnt_o),
        .perf_mem_stall_cnt_o (perf_mem_stall_cnt_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic in_t mkin(logic r, logic je, logic [31:0] ja, logic ld, logic [4:0] rd,
                                 logic [4:0] rs1, logic [4:0] rs2, logic u1, logic u2, logic busy);
        in_t x;
        x = '{rst: r, je: je, ja: ja, ld: ld, rd: rd, rs1: rs1, rs2: rs2, u1: u1, u2: u2, busy: busy};
        return x;
    endfunction

    function automatic out_t mkout(logic je, logic [31:0] ja, logic hpc, logic hif, logic hie,
                                   logic hem, logic fif, logic fie, logic err);
        out_t o;
        o = '{je: je, ja: ja, hpc: hpc, hif: hif, hie: hie, hem: hem, fif: fif, fie: fie, err: err};
        return o;
    endfunction

    task automatic drive(input in_t x);
        rst           = x.rst;
        jump_en_i     = x.je;
        jump_addr_i   = x.ja;
        ex_is_load_i  = x.ld;
        ex_rd_addr_i  = x.rd;
        id_rs1_addr_i = x.rs1;
        id_rs2_addr_i = x.rs2;
        id_rs1_used_i = x.u1;
        id_rs2_used_i = x.u2;
        mem_busy_i    = x.busy;
    endtask

    task automatic check(input string name, input out_t exp);
        out_t act;
        act = {jump_en_o, jump_addr_o, hold_pc_o, hold_if_id_o, hold_id_ex_o, hold_ex_mem_o,
               flush_if_id_o, flush_id_ex_o, err_timeout_o};
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got je=%b ja=%h hold=%b%b%b%b flush=%b%b err=%b, want je=%b ja=%h hold=%b%b%b%b flush=%b%b err=%b",
                     name, act.je, act.ja, act.hpc, act.hif, act.hie, act.hem, act.fif, act.fie, act.err,
                     exp.je, exp.ja, exp.hpc, exp.hif, exp.hie, exp.hem, exp.fif, exp.fie, exp.err);
        end else begin
            $display("ok   %s: je=%b ja=%h hold=%b%b%b%b flush=%b%b err=%b",
                     name, act.je, act.ja, act.hpc, act.hif, act.hie, act.hem, act.fif, act.fie, act.err);
        end
    endtask

    // One cycle: drive after the rising edge, check at the falling edge.
    task automatic cycle(input string name, input in_t x, input out_t exp);
        @(posedge clk);
        #1;
        drive(x);
        @(negedge clk);
        check(name, exp);
    endtask

    // Reference model: a pending redirect slot, a run length of busy cycles and a sticky error.
    bit          m_pend;
    logic [31:0] m_pend_addr;
    int          m_run;
    bit          m_err;

    function automatic out_t model_out(input in_t x);
        out_t o;
        bit   hit;
        o = '0;
        if (!x.rst) return o;
        o.ja  = m_pend ? m_pend_addr : x.ja;
        o.err = m_err;
        hit = x.ld && (x.rd != 0) && ((x.u1 && x.rs1 == x.rd) || (x.u2 && x.rs2 == x.rd));
        if (x.busy) begin
            {o.hpc, o.hif, o.hie, o.hem} = 4'b1111;
        end else if (m_pend || x.je) begin
            o.je  = 1'b1;
            o.fif = 1'b1;
            o.fie = 1'b1;
        end else if (hit) begin
            o.hpc = 1'b1;
            o.hif = 1'b1;
            o.fie = 1'b1;
        end
        return o;
    endfunction

    task automatic model_step(input in_t x);
        if (!x.rst) begin
            m_pend = 0; m_pend_addr = '0; m_run = 0; m_err = 0;
        end else if (x.busy) begin
            if (!m_pend && x.je) begin
                m_pend      = 1;
                m_pend_addr = x.ja;
            end
            m_run++;
            if (m_run >= TO) m_err = 1;
        end else begin
            m_pend = 0;
            m_run  = 0;
        end
    endtask

    vec_t tbl[20];

    initial begin
        in_t  x;
        out_t e;

        tbl[0]  = '{"rst_forced",    mkin(0,1,32'hdead,1,5,5,0,1,0,1), mkout(0,32'h0,0,0,0,0,0,0,0)};
        tbl[1]  = '{"idle",          mkin(1,0,32'h1234,0,0,0,0,0,0,0), mkout(0,32'h1234,0,0,0,0,0,0,0)};
        tbl[2]  = '{"lu_rs1",        mkin(1,0,32'h0,1,5,5,0,1,0,0),    mkout(0,32'h0,1,1,0,0,0,1,0)};
        tbl[3]  = '{"lu_clear",      mkin(1,0,32'h0,0,5,5,0,1,0,0),    mkout(0,32'h0,0,0,0,0,0,0,0)};
        tbl[4]  = '{"lu_rs2",        mkin(1,0,32'h0,1,7,3,7,1,1,0),    mkout(0,32'h0,1,1,0,0,0,1,0)};
        tbl[5]  = '{"rs2_unused",    mkin(1,0,32'h0,1,7,3,7,1,0,0),    mkout(0,32'h0,0,0,0,0,0,0,0)};
        tbl[6]  = '{"x0_load",       mkin(1,0,32'h0,1,0,0,0,1,1,0),    mkout(0,32'h0,0,0,0,0,0,0,0)};
        tbl[7]  = '{"jump_beats_lu", mkin(1,1,32'h100,1,5,5,0,1,0,0),  mkout(1,32'h100,0,0,0,0,1,1,0)};
        tbl[8]  = '{"busy_jump_0",   mkin(1,1,32'h200,0,0,0,0,0,0,1),  mkout(0,32'h200,1,1,1,1,0,0,0)};
        tbl[9]  = '{"busy_jump_1",   mkin(1,1,32'h300,0,0,0,0,0,0,1),  mkout(0,32'h200,1,1,1,1,0,0,0)};
        tbl[10] = '{"busy_jump_2",   mkin(1,1,32'h300,0,0,0,0,0,0,1),  mkout(0,32'h200,1,1,1,1,0,0,0)};
        tbl[11] = '{"pend_issue",    mkin(1,1,32'h300,1,5,5,0,1,0,0),  mkout(1,32'h200,0,0,0,0,1,1,0)};
        tbl[12] = '{"after_pend",    mkin(1,0,32'h44,0,0,0,0,0,0,0),   mkout(0,32'h44,0,0,0,0,0,0,0)};
        tbl[13] = '{"busy_nojump",   mkin(1,0,32'h44,0,0,0,0,0,0,1),   mkout(0,32'h44,1,1,1,1,0,0,0)};
        tbl[14] = '{"memwait_lu",    mkin(1,0,32'h44,1,5,5,0,1,0,0),   mkout(0,32'h44,1,1,0,0,0,1,0)};
        tbl[15] = '{"idle2",         mkin(1,0,32'h44,0,0,0,0,0,0,0),   mkout(0,32'h44,0,0,0,0,0,0,0)};
        tbl[16] = '{"mw_busy",       mkin(1,0,32'h44,0,0,0,0,0,0,1),   mkout(0,32'h44,1,1,1,1,0,0,0)};
        tbl[17] = '{"mw_jump",       mkin(1,1,32'h500,0,0,0,0,0,0,1),  mkout(0,32'h500,1,1,1,1,0,0,0)};
        tbl[18] = '{"mw_pend_issue", mkin(1,0,32'h9,0,0,0,0,0,0,0),    mkout(1,32'h500,0,0,0,0,1,1,0)};
        tbl[19] = '{"idle3",         mkin(1,0,32'h9,0,0,0,0,0,0,0),    mkout(0,32'h9,0,0,0,0,0,0,0)};

        drive(mkin(0,0,32'h0,0,0,0,0,0,0,0));
        cycle("reset_state", mkin(0,0,32'h0,0,0,0,0,0,0,0), mkout(0,32'h0,0,0,0,0,0,0,0));

        for (int i = 0; i < 20; i++) begin
            cycle(tbl[i].name, tbl[i].in, tbl[i].exp);
        end

        // Timeout: err becomes visible from the busy cycle after the TO-th consecutive one.
        for (int k = 1; k <= 6; k++) begin
            cycle($sformatf("timeout_busy%0d", k), mkin(1,0,32'h0,0,0,0,0,0,0,1),
                  mkout(0,32'h0,1,1,1,1,0,0,(k > TO) ? 1'b1 : 1'b0));
        end
        for (int k = 0; k < 2; k++) begin
            cycle("timeout_sticky", mkin(1,0,32'h0,0,0,0,0,0,0,0), mkout(0,32'h0,0,0,0,0,0,0,1));
        end
        cycle("timeout_in_rst", mkin(0,0,32'h0,0,0,0,0,0,0,0), mkout(0,32'h0,0,0,0,0,0,0,0));
        cycle("timeout_cleared", mkin(1,0,32'h0,0,0,0,0,0,0,0), mkout(0,32'h0,0,0,0,0,0,0,0));

        // Reset while a redirect is pending must discard it.
        cycle("rs_busy_jump", mkin(1,1,32'h700,0,0,0,0,0,0,1), mkout(0,32'h700,1,1,1,1,0,0,0));
        cycle("rs_pending",   mkin(1,0,32'h10,0,0,0,0,0,0,1),  mkout(0,32'h700,1,1,1,1,0,0,0));
        cycle("rs_in_rst",    mkin(0,0,32'h10,0,0,0,0,0,0,1),  mkout(0,32'h0,0,0,0,0,0,0,0));
        cycle("rs_no_jump",   mkin(1,0,32'h10,0,0,0,0,0,0,0),  mkout(0,32'h10,0,0,0,0,0,0,0));

        // Randomised run against the model, starting from a reset cycle.
        m_pend = 0; m_pend_addr = '0; m_run = 0; m_err = 0;
        for (int n = 0; n < 1000; n++) begin
            if (n == 0) begin
                x = mkin(0,0,32'h0,0,0,0,0,0,0,0);
            end else begin
                x.rst  = ($urandom_range(0, 99) >= 3);
                x.je   = ($urandom_range(0, 3) == 0);
                x.ja   = $urandom;
                x.ld   = 1'($urandom_range(0, 1));
                x.rd   = 5'($urandom_range(0, 3));
                x.rs1  = 5'($urandom_range(0, 3));
                x.rs2  = 5'($urandom_range(0, 3));
                x.u1   = 1'($urandom_range(0, 1));
                x.u2   = 1'($urandom_range(0, 1));
                x.busy = ($urandom_range(0, 9) < 5);
            end
            e = model_out(x);
            cycle($sformatf("rand%0d", n), x, e);
            model_step(x);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
